// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encoding and flag bundle for alu_seq.
// Imported by alu_seq; no ports.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    typedef struct packed {
        logic not_equal;
        logic less_than;
        logic overflow;
        logic div_by_zero;
        logic illegal_op;
    } flags_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 signed multiply / restoring divide, one bit per cycle.
// Ports: clock, reset_n (async, low), start/is_div/op_a/op_b in; done
// (1-cycle pulse on the last iteration), result, overflow out.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic               busy;
    logic               div_q;
    logic               neg;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0] sr;
    logic [2*WIDTH-1:0] sr_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;

    // -MIN wraps to MIN, which read unsigned is the correct magnitude
    assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

    // MUL: sr = {partial, multiplier}, acc = multiplicand.
    // DIV: sr = {remainder, dividend/quotient}, acc = divisor.
    always_comb begin
        mul_sum  = {1'b0, sr[2*WIDTH-1:WIDTH]}
                 + (sr[0] ? {1'b0, acc} : '0);
        div_diff = sr[2*WIDTH-1:WIDTH-1] - {1'b0, acc};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                sr_nxt = {div_diff[WIDTH-1:0], sr[WIDTH-2:0], 1'b1};
            end else begin
                sr_nxt = {sr[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            sr_nxt = {mul_sum, sr[WIDTH-1:1]};
        end
    end

    // Sign fixup works off sr_nxt so the result is ready on the last step
    always_comb begin
        prod = neg ? -sr_nxt : sr_nxt;
        quot = neg ? -sr_nxt[WIDTH-1:0] : sr_nxt[WIDTH-1:0];
        if (div_q) begin
            result   = quot;
            // only MIN/-1 yields a positive quotient of magnitude 2^(W-1)
            overflow = !neg && quot[WIDTH-1];
        end else begin
            result   = prod[WIDTH-1:0];
            overflow = prod[2*WIDTH-1:WIDTH-1]
                    != {(WIDTH+1){prod[WIDTH-1]}};
        end
    end

    assign done = busy && (cnt == CW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            neg   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            sr    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= is_div;
            neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            cnt   <= CW'(WIDTH);
            acc   <= is_div ? mag_b : mag_a;
            sr    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end else if (busy) begin
            sr  <= sr_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready on both sides; ADD/SUB/AND/OR/
// SLL/SRA in one cycle, iterative MUL/DIV when ALU_MULDIV_EN is defined.
// Ports: clock, reset_n; in_valid/in_ready, ctrl_ALUopcode, ctrl_shiftamt,
// data_operandA/B in; out_valid/out_ready, data_result and the flags out.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);

    logic [1:0]       rst_sync;
    logic             rst_n;
    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flg;
    logic [WIDTH-1:0] res_q;
    flags_t           flg_q;

    // Reset asserts asynchronously, releases on a clock edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign in_ready = rst_n && ((state == ST_IDLE)
                   || (state == ST_HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_flg = '0;
        sum     = data_operandA + data_operandB;
        diff    = data_operandA - data_operandB;
        sub_ovf = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1])
               && (diff[WIDTH-1] != data_operandA[WIDTH-1]);
        case (ctrl_ALUopcode)
            OP_ADD: begin
                alu_res = sum;
                alu_flg.overflow =
                    (data_operandA[WIDTH-1] == data_operandB[WIDTH-1])
                    && (sum[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_flg.overflow  = sub_ovf;
                // sign of the wrapped difference flips under overflow
                alu_flg.less_than = diff[WIDTH-1] ^ sub_ovf;
                alu_flg.not_equal = |(data_operandA ^ data_operandB);
            end
            OP_AND: alu_res = data_operandA & data_operandB;
            OP_OR:  alu_res = data_operandA | data_operandB;
            OP_SLL: alu_res = data_operandA << ctrl_shiftamt;
            OP_SRA: alu_res = $signed(data_operandA) >>> ctrl_shiftamt;
`ifdef ALU_MULDIV_EN
            OP_MUL: alu_res = '0;
            // only reaches the registers when B == 0
            OP_DIV: alu_flg.div_by_zero = 1'b1;
`endif
            default: alu_flg.illegal_op = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             go_mul;
    logic             go_div;
    logic             md_done;
    logic             md_ovf;
    logic [WIDTH-1:0] md_res;
    flags_t           md_flg;

    assign go_mul = accept && (ctrl_ALUopcode == OP_MUL);
    assign go_div = accept && (ctrl_ALUopcode == OP_DIV)
                 && (|data_operandB);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clock    (clock),
        .reset_n  (rst_n),
        .start    (go_mul || go_div),
        .is_div   (go_div),
        .op_a     (data_operandA),
        .op_b     (data_operandB),
        .done     (md_done),
        .result   (md_res),
        .overflow (md_ovf)
    );

    always_comb begin
        md_flg          = '0;
        md_flg.overflow = md_ovf;
    end
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            res_q <= '0;
            flg_q <= '0;
        end else if (accept) begin
`ifdef ALU_MULDIV_EN
            if (go_mul) begin
                state <= ST_MUL;
            end else if (go_div) begin
                state <= ST_DIV;
            end else begin
                state <= ST_HOLD;
                res_q <= alu_res;
                flg_q <= alu_flg;
            end
`else
            state <= ST_HOLD;
            res_q <= alu_res;
            flg_q <= alu_flg;
`endif
        end else begin
            case (state)
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
`ifdef ALU_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        state <= ST_HOLD;
                        res_q <= md_res;
                        flg_q <= md_flg;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign out_valid   = (state == ST_HOLD);
    assign data_result = res_q;
    assign isNotEqual  = flg_q.not_equal;
    assign isLessThan  = flg_q.less_than;
    assign overflow    = flg_q.overflow;
    assign div_by_zero = flg_q.div_by_zero;
    assign illegal_op  = flg_q.illegal_op;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written handshake/reset sequences
// and randomized ops checked against a wide-arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int ML = MD ? 33 : 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  ctrl_ALUopcode = '0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;
    logic        div_by_zero;
    logic        illegal_op;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .div_by_zero    (div_by_zero),
        .illegal_op     (illegal_op)
    );

    function automatic logic [4:0] dut_flags();
        return {isNotEqual, isLessThan, overflow, div_by_zero, illegal_op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit out_of_range(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Reference: full-precision signed arithmetic, then truncate
    function automatic exp_t model(input logic [4:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t e;
        longint sa, sb, w;
        logic signed [31:0] a32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        a32 = a;
        e.res = '0;
        e.flg = '0;
        e.lat = 1;
        if (op == 5'd0) begin
            w = sa + sb;
            e.res = w[31:0];
            e.flg[2] = out_of_range(w);
        end else if (op == 5'd1) begin
            w = sa - sb;
            e.res = w[31:0];
            e.flg[2] = out_of_range(w);
            e.flg[3] = (sa < sb);
            e.flg[4] = (a != b);
        end else if (op == 5'd2) begin
            e.res = a & b;
        end else if (op == 5'd3) begin
            e.res = a | b;
        end else if (op == 5'd4) begin
            e.res = a << sh;
        end else if (op == 5'd5) begin
            e.res = a32 >>> sh;
        end else if (op == 5'd6 && MD) begin
            w = sa * sb;
            e.res = w[31:0];
            e.flg[2] = out_of_range(w);
            e.lat = 33;
        end else if (op == 5'd7 && MD) begin
            if (sb == 0) begin
                e.flg[1] = 1'b1;
            end else begin
                w = sa / sb;
                e.res = w[31:0];
                e.flg[2] = out_of_range(w);
                e.lat = 33;
            end
        end else begin
            e.flg[0] = 1'b1;
        end
        return e;
    endfunction

    // Starts and ends just after a rising edge with the block idle.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input exp_t e,
                          input int drain);
        int n;
        bit busy_ok;
        ctrl_ALUopcode = op;
        data_operandA = a;
        data_operandB = b;
        ctrl_shiftamt = sh;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'(1));
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        data_operandA = ~a;
        data_operandB = ~b;
        n = 1;
        busy_ok = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(e.lat));
        chk({tag, "_res"}, 64'(data_result), 64'(e.res));
        chk({tag, "_flags"}, 64'(dut_flags()), 64'(e.flg));
        if (e.lat > 1) chk({tag, "_busy"}, 64'(busy_ok), 64'(1));
        if (drain > 0) begin
            repeat (drain) begin
                @(posedge clock);
            end
            #1;
            chk({tag, "_held"}, {31'd0, out_valid, data_result},
                {31'd0, 1'b1, e.res});
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_out", {30'd0, out_valid, in_ready, data_result},
            64'(0));
        chk("rst_flags", 64'(dut_flags()), 64'(0));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10 && !in_ready; i++) begin
            @(posedge clock); #1;
        end
        chk("rst_release_ready", 64'(in_ready), 64'(1));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[$];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        exp_t e;
        logic [31:0] ea[10];
        logic [4:0] op;
        logic [31:0] a, b;
        bit rdy_ok;

        vecs.push_back('{5'd0, 32'h7FFFFFFF, 32'd1, 5'd0,
                         32'h80000000, 5'b00100, 1});
        vecs.push_back('{5'd1, 32'd5, 32'd7, 5'd0,
                         32'hFFFFFFFE, 5'b11000, 1});
        vecs.push_back('{5'd1, 32'h80000000, 32'd1, 5'd0,
                         32'h7FFFFFFF, 5'b11100, 1});
        vecs.push_back('{5'd1, 32'd3, 32'd3, 5'd0,
                         32'd0, 5'b00000, 1});
        vecs.push_back('{5'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,
                         32'h00F000F0, 5'b00000, 1});
        vecs.push_back('{5'd3, 32'h12340000, 32'h00005678, 5'd0,
                         32'h12345678, 5'b00000, 1});
        vecs.push_back('{5'd4, 32'd1, 32'd0, 5'd31,
                         32'h80000000, 5'b00000, 1});
        vecs.push_back('{5'd4, 32'hDEADBEEF, 32'd0, 5'd0,
                         32'hDEADBEEF, 5'b00000, 1});
        vecs.push_back('{5'd5, 32'h80000000, 32'd0, 5'd4,
                         32'hF8000000, 5'b00000, 1});
        vecs.push_back('{5'd5, 32'h7FFFFFFF, 32'd0, 5'd31,
                         32'd0, 5'b00000, 1});
        vecs.push_back('{5'd8, 32'd5, 32'd6, 5'd0,
                         32'd0, 5'b00001, 1});
        vecs.push_back('{5'd31, 32'd5, 32'd6, 5'd0,
                         32'd0, 5'b00001, 1});
        if (MD) begin
            vecs.push_back('{5'd6, 32'hFFFFFFFD, 32'd7, 5'd0,
                             32'hFFFFFFEB, 5'b00000, ML});
            vecs.push_back('{5'd6, 32'h10000, 32'h10000, 5'd0,
                             32'd0, 5'b00100, ML});
            vecs.push_back('{5'd6, 32'h80000000, 32'hFFFFFFFF, 5'd0,
                             32'h80000000, 5'b00100, ML});
            vecs.push_back('{5'd7, 32'hFFFFFFF9, 32'd2, 5'd0,
                             32'hFFFFFFFD, 5'b00000, ML});
            vecs.push_back('{5'd7, 32'h80000000, 32'hFFFFFFFF, 5'd0,
                             32'h80000000, 5'b00100, ML});
            vecs.push_back('{5'd7, 32'd9, 32'd0, 5'd0,
                             32'd0, 5'b00010, 1});
            vecs.push_back('{5'd7, 32'd0, 32'hFFFFFFFB, 5'd0,
                             32'd0, 5'b00000, ML});
        end else begin
            vecs.push_back('{5'd6, 32'hFFFFFFFD, 32'd7, 5'd0,
                             32'd0, 5'b00001, 1});
            vecs.push_back('{5'd7, 32'd9, 32'd0, 5'd0,
                             32'd0, 5'b00001, 1});
        end

        @(posedge clock); #1;
        do_reset();

        foreach (vecs[i]) begin
            e.res = vecs[i].res;
            e.flg = vecs[i].flg;
            e.lat = vecs[i].lat;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                   vecs[i].b, vecs[i].sh, e, 0);
        end

        // back-to-back ANDs, one result per cycle
        rdy_ok = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            ea[i] = a & b;
            ctrl_ALUopcode = 5'd2;
            data_operandA = a;
            data_operandB = b;
            in_valid = 1'b1;
            #1;
            if (!in_ready) rdy_ok = 1'b0;
            @(posedge clock); #1;
            chk($sformatf("b2b%0d", i), {31'd0, out_valid, data_result},
                {31'd0, 1'b1, ea[i]});
        end
        in_valid = 1'b0;
        chk("b2b_ready", 64'(rdy_ok), 64'(1));
        @(posedge clock); #1;
        out_ready = 1'b0;

        // hold under backpressure, new op waits for the drain
        ctrl_ALUopcode = 5'd5;
        data_operandA = 32'h80000000;
        ctrl_shiftamt = 5'd4;
        in_valid = 1'b1;
        #1;
        @(posedge clock); #1;
        ctrl_ALUopcode = 5'd0;
        data_operandA = 32'd1;
        data_operandB = 32'd2;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d", i),
                {30'd0, out_valid, in_ready, data_result},
                {30'd0, 1'b1, 1'b0, 32'hF8000000});
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_ready", 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("hold_next", {26'd0, out_valid, dut_flags(), data_result},
            {26'd0, 1'b1, 5'b00000, 32'd3});
        @(posedge clock); #1;
        out_ready = 1'b0;

        // reset in the middle of a long op
        e = model(5'd0, 32'd1, 32'd2, 5'd0);
        run_op("pre_rst", 5'd0, 32'd1, 32'd2, 5'd0, e, 0);
        ctrl_ALUopcode = MD ? 5'd7 : 5'd0;
        data_operandA = 32'd100;
        data_operandB = 32'd3;
        in_valid = 1'b1;
        #1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clock);
        end
        #1;
        chk("mid_op_valid", 64'(out_valid), 64'(!MD));
        do_reset();
        e = model(5'd0, 32'd20, 32'd22, 5'd0);
        run_op("post_rst", 5'd0, 32'd20, 32'd22, 5'd0, e, 0);

        // randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 9) < 9) ? 5'($urandom_range(0, 7))
                                            : 5'($urandom_range(8, 31));
            a = rnd_operand();
            b = rnd_operand();
            e = model(op, a, b, 5'($urandom_range(0, 31)));
            e = model(op, a, b, ctrl_shiftamt);
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b,
                   ctrl_shiftamt, e, $urandom_range(0, 2));
            ctrl_shiftamt = 5'($urandom_range(0, 31));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
